// File: rtl/sr_div_seq.sv
// Sequential 32-bit divider for the RISC-V M extension (DIV, DIVU, REM, REMU).
// Restoring radix-2, one quotient bit per cycle; zero-divisor and signed-overflow cases finish immediately.
module sr_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [2:0]  oper,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result
);

    // Handshake: start is taken on a rising edge only while busy is low and oper[2] is set;
    // valid is a single-cycle pulse with result already updated, and a start in that same
    // cycle launches the next op with no idle gap.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        accept;
    logic        is_signed;
    logic        is_rem;
    logic        div_zero;
    logic        ovf;
    logic        special;
    logic [31:0] special_res;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dsr_q;
    logic [4:0]  cnt_q;
    logic        op_rem_q;
    logic        neg_q_q;
    logic        neg_r_q;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic        last;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] calc_res;

    assign accept    = start && oper[2] && ((state == IDLE) || (state == DONE));
    assign is_signed = ~oper[0];
    assign is_rem    = oper[1];
    assign div_zero  = (srcB == 32'd0);
    assign ovf       = is_signed && (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
    assign special   = div_zero || ovf;

    always_comb begin
        special_res = 32'd0;
        if (div_zero)
            special_res = is_rem ? srcA : 32'hFFFF_FFFF;
        else
            special_res = is_rem ? 32'd0 : 32'h8000_0000;
    end

    assign abs_a = (is_signed && srcA[31]) ? (~srcA + 32'd1) : srcA;
    assign abs_b = (is_signed && srcB[31]) ? (~srcB + 32'd1) : srcB;

    // Partial remainder stays below the divisor, so a negative 33-bit difference means "no subtract".
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {1'b0, dsr_q};
    assign ge       = ~diff[32];
    assign rem_nxt  = ge ? diff[31:0] : shifted[31:0];
    assign quo_nxt  = {quo_q[30:0], ge};
    assign last     = (state == CALC) && (cnt_q == 5'd31);
    assign q_fix    = neg_q_q ? (~quo_nxt + 32'd1) : quo_nxt;
    assign r_fix    = neg_r_q ? (~rem_nxt + 32'd1) : rem_nxt;
    assign calc_res = op_rem_q ? r_fix : q_fix;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = special ? DONE : CALC;
            end
            CALC: begin
                if (cnt_q == 5'd31)
                    state_nxt = DONE;
            end
            DONE: begin
                if (accept)
                    state_nxt = special ? DONE : CALC;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == CALC);
        valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            quo_q    <= abs_a;
            rem_q    <= 32'd0;
            dsr_q    <= abs_b;
            cnt_q    <= 5'd0;
            op_rem_q <= is_rem;
            neg_q_q  <= is_signed && (srcA[31] ^ srcB[31]);
            neg_r_q  <= is_signed && srcA[31];
        end else if (state == CALC) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            result <= 32'd0;
        else if (accept && special)
            result <= special_res;
        else if (last)
            result <= calc_res;
    end

endmodule

// File: tb/tb_sr_div_seq.sv
// Self-checking bench for sr_div_seq: directed RISC-V divide cases, control corner cases
// and random operands against an arithmetic reference model.
module tb_sr_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [2:0]  oper;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    sr_div_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .srcA   (srcA),
        .srcB   (srcB),
        .oper   (oper),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    localparam logic [2:0]  D_OP [12] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM,
                                          OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_REM};
    localparam logic [31:0] D_A  [12] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                                          32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
    localparam logic [31:0] D_B  [12] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                          32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    localparam logic [31:0] D_EXP[12] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1,
                                          32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};

    // Reference: RISC-V M semantics from plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op[1:0])
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Issues one start (call at a sample point while not busy) and waits for valid.
    // Returns in the DONE cycle, so an immediate second call is a back-to-back start.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int nbusy, output bit got);
        start = 1'b1;
        oper  = op;
        srcA  = a;
        srcB  = b;
        @(posedge clk); #1;
        start = 1'b0;
        oper  = 3'($urandom);
        srcA  = $urandom;
        srcB  = $urandom;
        lat   = -1;
        nbusy = 0;
        got   = 1'b0;
        res   = 32'd0;
        for (int k = 0; k < 40; k++) begin
            if (valid) begin
                got = 1'b1;
                lat = k;
                res = result;
                break;
            end
            if (busy) nbusy++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; oper = OP_DIVU; srcA = 32'd9; srcB = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b result=%h, required 0 0 00000000", busy, valid, result);
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: busy=%b valid=%b after start held with rst, required 0 0", busy, valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] res;
        int lat, nb;
        bit got;
        for (int i = 0; i < 12; i++) begin
            run_op(D_OP[i], D_A[i], D_B[i], res, lat, nb, got);
            checks++;
            if (!got || res !== D_EXP[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got=%0b result=%h, required %h", i, got, res, D_EXP[i]);
            end
            checks++;
            if (lat != ref_lat(D_OP[i], D_A[i], D_B[i]) || nb != ref_lat(D_OP[i], D_A[i], D_B[i])) begin
                errors++;
                $display("FAIL directed_latency[%0d]: valid after %0d cycles, busy %0d cycles, required %0d",
                         i, lat, nb, ref_lat(D_OP[i], D_A[i], D_B[i]));
            end
            @(posedge clk); #1;
            checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || result !== D_EXP[i]) begin
                errors++;
                $display("FAIL directed_hold[%0d]: valid=%b busy=%b result=%h, required 0 0 %h",
                         i, valid, busy, result, D_EXP[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int pulses = 0;
        int lat = -1;
        logic [31:0] res = 32'd0;
        logic [31:0] exp = ref_div(OP_DIVU, 32'd1000, 32'd3);
        start = 1'b1; oper = OP_DIVU; srcA = 32'd1000; srcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 45; k++) begin
            if (k == 5) begin
                start = 1'b1; oper = OP_DIV; srcA = 32'd77; srcB = 32'd5;
            end
            if (k == 6) start = 1'b0;
            if (valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    res = result;
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 1 || lat != 32 || res !== exp) begin
            errors++;
            $display("FAIL start_while_busy: pulses=%0d latency=%0d result=%h, required 1 32 %h", pulses, lat, res, exp);
        end
    endtask

    task automatic test_ignored_oper();
        int bad = 0;
        for (int j = 0; j < 4; j++) begin
            start = 1'b1; oper = 3'(j); srcA = $urandom; srcB = $urandom_range(1, 100);
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (busy !== 1'b0 || valid !== 1'b0) bad++;
                @(posedge clk); #1;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ignored_mul_oper: %0d cycles with busy/valid high, required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        int l1, l2, b1, b2;
        bit g1, g2;
        run_op(OP_REM, 32'hFFFF_FF00, 32'd13, r1, l1, b1, g1);
        run_op(OP_DIVU, 32'hDEAD_BEEF, 32'd1234, r2, l2, b2, g2);
        checks++;
        if (!g1 || r1 !== ref_div(OP_REM, 32'hFFFF_FF00, 32'd13)) begin
            errors++;
            $display("FAIL b2b_first: result=%h, required %h", r1, ref_div(OP_REM, 32'hFFFF_FF00, 32'd13));
        end
        checks++;
        if (!g2 || r2 !== ref_div(OP_DIVU, 32'hDEAD_BEEF, 32'd1234) || l2 != 32 || b2 != 32) begin
            errors++;
            $display("FAIL b2b_second: result=%h latency=%0d busy=%0d, required %h 32 32",
                     r2, l2, b2, ref_div(OP_DIVU, 32'hDEAD_BEEF, 32'd1234));
        end
        run_op(OP_DIV, 32'd40, 32'd0, r1, l1, b1, g1);
        checks++;
        if (!g1 || r1 !== 32'hFFFF_FFFF || l1 != 0) begin
            errors++;
            $display("FAIL b2b_special: result=%h latency=%0d, required ffffffff 0", r1, l1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        int pulses = 0;
        start = 1'b1; oper = OP_DIVU; srcA = $urandom; srcB = $urandom_range(1, 1000);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_calc_busy: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b valid=%b result=%h, required 0 0 00000000", busy, valid, result);
        end
        for (int k = 0; k < 40; k++) begin
            if (valid) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_no_valid: %0d valid pulses after abort, required 0", pulses);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res;
        int lat, nb;
        bit got;
        for (int i = 0; i < 80; i++) begin
            op = {1'b1, 2'($urandom)};
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 50);
                default: ;
            endcase
            run_op(op, a, b, res, lat, nb, got);
            checks++;
            if (!got || res !== ref_div(op, a, b) || lat != ref_lat(op, a, b)) begin
                errors++;
                $display("FAIL random[%0d]: op=%b a=%h b=%h result=%h latency=%0d, required %h %0d",
                         i, op, a, b, res, lat, ref_div(op, a, b), ref_lat(op, a, b));
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; oper = 3'b000; srcA = 32'd0; srcB = 32'd0;
        test_reset();
        test_directed();
        test_start_while_busy();
        test_ignored_oper();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_div_seq.md
SR_DIV_SEQ -- requirements
Module: sr_div_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state changes on rising edge), rst input 1 (synchronous, active-high).
REQ-002 The block SHALL expose these ports, listed as name, direction, width, meaning:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a divide op, sampled on a rising edge.
- srcA  input  32  dividend.
- srcB  input  32  divisor.
- oper  input  3  RISC-V M funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- busy  output  1  a divide is in progress and a new start is not accepted.
- valid  output  1  one-cycle pulse; result holds the finished value.
- result  output  32  quotient or remainder of the last completed op.
REQ-003 The block SHALL have no parameters; width fixed at 32.

Function
REQ-004 The state machine SHALL have exactly three states: IDLE, CALC, DONE.
REQ-005 A start SHALL be accepted when state is IDLE or DONE and oper[2]==1; start with oper[2]==0 SHALL be ignored (multiply ops belong to the combinational MDU).
REQ-006 On acceptance the block SHALL capture srcA, srcB and oper internally; later input changes SHALL NOT affect the op.
REQ-007 Signed ops (DIV, REM) SHALL divide absolute values and record the quotient sign (sign A xor sign B) and remainder sign (sign A); unsigned ops SHALL use raw operands.
REQ-008 Normal ops SHALL take the path IDLE/DONE -> CALC -> DONE, using restoring radix-2 division with one quotient bit per CALC cycle, MSB first, for exactly 32 CALC cycles via a 5-bit iteration counter.
REQ-009 Normal-op latency: if start is accepted at edge E0, valid SHALL be high in the cycle after edge E32 (33 cycles after the start cycle).
REQ-010 If divisor==0, or if the op is DIV/REM with srcA==0x80000000 and srcB==0xFFFFFFFF, the block SHALL skip CALC and go directly to DONE (valid in the cycle after E0).
REQ-011 Divide-by-zero results SHALL be: DIV 0xFFFFFFFF; DIVU 0xFFFFFFFF; REM and REMU the dividend.
REQ-012 Signed-overflow results SHALL be: DIV 0x80000000; REM 0x00000000.
REQ-013 Normal results SHALL be: DIV/DIVU the quotient, sign-corrected for DIV; REM/REMU the remainder, sign-corrected for REM (remainder takes the dividend's sign).
REQ-014 busy SHALL be 1 exactly when state==CALC.
REQ-015 valid SHALL be 1 exactly when state==DONE, and DONE SHALL last one cycle.
REQ-016 From DONE the next state SHALL be CALC or DONE if a start is accepted that cycle (back-to-back), else IDLE.
REQ-017 result SHALL be registered and updated only on entry to DONE; it SHALL hold its value in IDLE and CALC until the next completion.
REQ-018 start while busy SHALL be ignored, with no queuing and no effect on the op in flight.

Reset
REQ-019 When rst is high at a rising edge: state SHALL become IDLE, and busy, valid and result SHALL all be 0.
REQ-020 Reset SHALL take priority over start at the same edge.
REQ-021 Reset during CALC SHALL abort the op; no valid pulse SHALL follow.
REQ-022 Internal operand, counter and sign registers need not be reset, but their values SHALL never reach result before a completed op.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- DIVU 100/7: start at edge E0 -> busy for 32 cycles, valid one cycle after E32, result 14; REMU same operands -> 2.
- DIV -7 (0xFFFFFFF9) / 2 -> result 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIV 7 / -2 -> 0xFFFFFFFD; REM 7 / -2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF with valid the cycle after E0; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 one cycle after E0; REM same operands -> 0.
- Start pulsed again mid-CALC with different operands -> ignored, first result unchanged, exactly one valid pulse. Start with oper=000 in IDLE -> busy stays 0, no valid.
- Back-to-back: new start in the DONE cycle -> busy high the next cycle, no IDLE gap, second result correct.
- rst asserted at CALC cycle 10 -> next cycle busy=0, valid=0, result=0, and no valid pulse afterwards.
REQ-024 The bench SHALL also run random operands for all four ops, compared against a reference model implementing REQ-011 to REQ-013.
